// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader for a core's program memory
//
// Receives SYNC, LEN, LEN payload bytes, CSUM (XOR of LEN and payload) on a
// valid/ready byte stream, writes the payload to program memory starting at
// word 0, pads the remaining words with FILL_BYTE, then releases the core.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/in_valid   host byte stream
//   in_ready           loader accepts a byte this cycle
//   ld_we/addr/data    registered write port into program memory
//   cpu_run            core released to execute (DONE state only)
//   busy               frame in progress (LEN, DATA, CSUM, FILL)
//   err, err_code      sticky error flag and cause (1 length, 2 csum, 3 timeout)
module prog_loader #(
   parameter int         MEM_DEPTH = 19,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] FILL_BYTE = 8'h0A,
   parameter int         TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ld_we,
   output logic [4:0] ld_addr,
   output logic [7:0] ld_data,
   output logic       cpu_run,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int         GW     = $clog2(TIMEOUT + 1);
   localparam logic [7:0] DEPTH8 = 8'(MEM_DEPTH);
   localparam logic [7:0] LAST8  = 8'(MEM_DEPTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE
   } state_t;

   state_t          state, state_n;
   logic [7:0]      len_q;
   logic [7:0]      csum_q;
   logic [7:0]      idx_q;
   logic [GW-1:0]   gap_q;
   logic            xfer;
   logic            in_frame;
   logic            timeout_hit;
   logic            len_ok;
   logic            is_sync;

   assign in_ready    = !rst && (state != S_FILL);
   assign busy        = !rst && (state == S_LEN || state == S_DATA ||
                                 state == S_CSUM || state == S_FILL);
   assign cpu_run     = !rst && (state == S_DONE);

   assign xfer        = in_valid && in_ready;
   assign is_sync     = (in_data == SYNC_BYTE);
   assign len_ok      = (in_data != 8'd0) && (in_data <= DEPTH8);
   assign in_frame    = (state == S_LEN || state == S_DATA || state == S_CSUM);
   // Fires on the TIMEOUT-th consecutive idle cycle inside a frame.
   assign timeout_hit = in_frame && !xfer && (gap_q == GAP_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: if (xfer && is_sync) state_n = S_LEN;
         S_LEN: begin
            if (timeout_hit)  state_n = S_IDLE;
            else if (xfer)    state_n = len_ok ? S_DATA : S_IDLE;
         end
         S_DATA: begin
            if (timeout_hit)                           state_n = S_IDLE;
            else if (xfer && (idx_q + 8'd1) == len_q)  state_n = S_CSUM;
         end
         S_CSUM: begin
            if (timeout_hit) state_n = S_IDLE;
            else if (xfer)   state_n = (in_data == csum_q) ? S_FILL : S_IDLE;
         end
         // idx_q == MEM_DEPTH means a full-length frame: one idle FILL cycle.
         S_FILL:  if (idx_q >= LAST8) state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_we    <= 1'b0;
         ld_addr  <= '0;
         ld_data  <= '0;
         err      <= 1'b0;
         err_code <= 2'd0;
         len_q    <= '0;
         csum_q   <= '0;
         idx_q    <= '0;
         gap_q    <= '0;
      end else begin
         ld_we <= 1'b0;

         if (!in_frame || xfer)      gap_q <= '0;
         else if (gap_q != GAP_MAX)  gap_q <= gap_q + 1'b1;

         case (state)
            S_IDLE, S_DONE: begin
               if (xfer && is_sync) begin
                  err      <= 1'b0;
                  err_code <= 2'd0;
               end
            end
            S_LEN: begin
               if (timeout_hit) begin
                  err      <= 1'b1;
                  err_code <= 2'd3;
               end else if (xfer) begin
                  if (len_ok) begin
                     len_q  <= in_data;
                     csum_q <= in_data;
                     idx_q  <= '0;
                  end else begin
                     err      <= 1'b1;
                     err_code <= 2'd1;
                  end
               end
            end
            S_DATA: begin
               if (timeout_hit) begin
                  err      <= 1'b1;
                  err_code <= 2'd3;
               end else if (xfer) begin
                  ld_we   <= 1'b1;
                  ld_addr <= idx_q[4:0];
                  ld_data <= in_data;
                  csum_q  <= csum_q ^ in_data;
                  idx_q   <= idx_q + 8'd1;
               end
            end
            S_CSUM: begin
               if (timeout_hit) begin
                  err      <= 1'b1;
                  err_code <= 2'd3;
               end else if (xfer && in_data != csum_q) begin
                  err      <= 1'b1;
                  err_code <= 2'd2;
               end
            end
            S_FILL: begin
               if (idx_q < DEPTH8) begin
                  ld_we   <= 1'b1;
                  ld_addr <= idx_q[4:0];
                  ld_data <= FILL_BYTE;
                  idx_q   <= idx_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
